// File: rtl/riscv_writeback.sv
// -----------------------------------------------------------------------------
// riscv_writeback
//   Writeback stage driving the register file write port. Accepts one retiring
//   instruction per valid/ready handshake, selects ALU result, formatted load
//   data or PC+4, and issues AddrD_o WB_ADDR_LEAD cycles ahead of the matching
//   DataD_o/RegWEn_o, because the register file delays the address internally.
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         synchronous reset, active low
//   wb_valid_i     memory stage has an instruction to retire
//   wb_ready_o     stage can accept (valid & ready = transfer)
//   wb_rd_i        destination register
//   wb_sel_i       00 ALU, 01 LOAD, 10 PC+4, 11 no write
//   wb_alu_i       ALU result
//   wb_pc_i        instruction PC
//   wb_funct3_i    load type (LB/LH/LW/LBU/LHU)
//   wb_addr_lo_i   load byte offset
//   dmem_rvalid_i  data memory read response valid
//   dmem_rdata_i   aligned data memory read word
//   AddrD_o        regfile write address (leads data)
//   DataD_o        regfile write data
//   RegWEn_o       regfile write enable
//   err_o          one-cycle pulse on misaligned/illegal load (or timeout)
//
// Configuration
//   WB_LOAD_TIMEOUT_EN  when defined, a load waiting TIMEOUT_CYCLES cycles
//                       without a response is abandoned with an err_o pulse.
// -----------------------------------------------------------------------------
module riscv_writeback #(
  parameter int XLEN           = 32,
  parameter int WB_ADDR_LEAD   = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wb_valid_i,
  output logic            wb_ready_o,
  input  logic [4:0]      wb_rd_i,
  input  logic [1:0]      wb_sel_i,
  input  logic [XLEN-1:0] wb_alu_i,
  input  logic [XLEN-1:0] wb_pc_i,
  input  logic [2:0]      wb_funct3_i,
  input  logic [1:0]      wb_addr_lo_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic [4:0]      AddrD_o,
  output logic [XLEN-1:0] DataD_o,
  output logic            RegWEn_o,
  output logic            err_o
);

  typedef enum logic {
    S_IDLE,
    S_LOAD_WAIT
  } state_t;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] data;
  } entry_t;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  state_t          r_state;
  state_t          w_state_nxt;

  // Load context captured at accept time; the response arrives later.
  logic [4:0]      r_rd;
  logic [2:0]      r_funct3;
  logic [1:0]      r_addr_lo;

  entry_t          r_dly [WB_ADDR_LEAD];
  entry_t          r_out;
  logic [4:0]      r_addr;
  logic            r_err;

  logic            w_push;
  logic [4:0]      w_push_rd;
  entry_t          w_push_entry;
  logic            w_err;

  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load_data;
  logic            w_load_err;
  logic            w_timeout;

  // ---------------------------------------------------------------------------
  // Load formatting and legality
  // ---------------------------------------------------------------------------
  assign w_byte = dmem_rdata_i[{r_addr_lo, 3'b000} +: 8];
  assign w_half = dmem_rdata_i[{r_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can leave it unassigned (latch).
    w_load_data = '0;
    w_load_err  = 1'b0;
    unique case (r_funct3)
      3'b000: w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001: begin
        w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
        w_load_err  = r_addr_lo[0];
      end
      3'b010: begin
        w_load_data = dmem_rdata_i;
        w_load_err  = (r_addr_lo != 2'b00);
      end
      3'b100: w_load_data = {{(XLEN-8){1'b0}}, w_byte};
      3'b101: begin
        w_load_data = {{(XLEN-16){1'b0}}, w_half};
        w_load_err  = r_addr_lo[0];
      end
      default: w_load_err = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Optional load timeout
  // ---------------------------------------------------------------------------
`ifdef WB_LOAD_TIMEOUT_EN
  localparam int            TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_timer;

  // Held at zero outside LOAD_WAIT, so it starts from zero on every entry.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || r_state == S_IDLE) r_timer <= '0;
    else                              r_timer <= r_timer + TW'(1);
  end

  assign w_timeout = (r_state == S_LOAD_WAIT) && !dmem_rvalid_i && (r_timer == TMAX);
`else
  assign w_timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM next state and push selection
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_push       = 1'b0;
    w_push_rd    = '0;
    w_push_entry = '0;
    w_err        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (wb_valid_i) begin
          if (wb_sel_i == SEL_LOAD) begin
            w_state_nxt = S_LOAD_WAIT;
          end else if (wb_sel_i == SEL_ALU || wb_sel_i == SEL_PC4) begin
            w_push    = 1'b1;
            w_push_rd = wb_rd_i;
            // Writes to x0 travel as bubbles so the regfile never sees them.
            if (wb_rd_i != 5'd0) begin
              w_push_entry.we   = 1'b1;
              w_push_entry.data = (wb_sel_i == SEL_ALU) ? wb_alu_i
                                                        : wb_pc_i + XLEN'(4);
            end
          end
          // sel=11 retires with no write: a plain bubble enters the line.
        end
      end
      S_LOAD_WAIT: begin
        if (dmem_rvalid_i) begin
          w_push      = 1'b1;
          w_push_rd   = r_rd;
          w_err       = w_load_err;
          w_state_nxt = S_IDLE;
          if (r_rd != 5'd0 && !w_load_err) begin
            w_push_entry.we   = 1'b1;
            w_push_entry.data = w_load_data;
          end
        end else if (w_timeout) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, capture and delay line
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // NOTE: the delay line is reset, not left to flush, because entries
      // queued before reset must never reach the register file afterwards.
      r_state   <= S_IDLE;
      r_rd      <= '0;
      r_funct3  <= '0;
      r_addr_lo <= '0;
      r_addr    <= '0;
      r_err     <= 1'b0;
      r_out     <= '0;
      for (int i = 0; i < WB_ADDR_LEAD; i++) r_dly[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register here sample the
      // pre-edge values, which is what lets the delay line shift correctly.
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && wb_valid_i && wb_sel_i == SEL_LOAD) begin
        r_rd      <= wb_rd_i;
        r_funct3  <= wb_funct3_i;
        r_addr_lo <= wb_addr_lo_i;
      end
      r_addr   <= w_push ? w_push_rd : 5'd0;
      r_err    <= w_err;
      r_dly[0] <= w_push_entry;
      for (int i = 1; i < WB_ADDR_LEAD; i++) r_dly[i] <= r_dly[i-1];
      // Output register adds the last cycle: entry pushed at edge E shows
      // at edge E+WB_ADDR_LEAD.
      r_out <= r_dly[WB_ADDR_LEAD-1];
    end
  end

  assign wb_ready_o = rst_ni && (r_state == S_IDLE);
  assign AddrD_o    = r_addr;
  assign DataD_o    = r_out.data;
  assign RegWEn_o   = r_out.we;
  assign err_o      = r_err;

endmodule

// File: tb/tb_riscv_writeback.sv
// -----------------------------------------------------------------------------
// tb_riscv_writeback
//   Directed, self-checking bench for riscv_writeback. Inputs change 1 ns
//   after a rising edge; outputs are checked at that same point, well away
//   from the next active edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_riscv_writeback;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            wb_valid_i;
  logic            wb_ready_o;
  logic [4:0]      wb_rd_i;
  logic [1:0]      wb_sel_i;
  logic [XLEN-1:0] wb_alu_i;
  logic [XLEN-1:0] wb_pc_i;
  logic [2:0]      wb_funct3_i;
  logic [1:0]      wb_addr_lo_i;
  logic            dmem_rvalid_i;
  logic [XLEN-1:0] dmem_rdata_i;
  logic [4:0]      AddrD_o;
  logic [XLEN-1:0] DataD_o;
  logic            RegWEn_o;
  logic            err_o;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_writeback #(.XLEN(XLEN), .WB_ADDR_LEAD(3), .TIMEOUT_CYCLES(16)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .wb_valid_i   (wb_valid_i),
    .wb_ready_o   (wb_ready_o),
    .wb_rd_i      (wb_rd_i),
    .wb_sel_i     (wb_sel_i),
    .wb_alu_i     (wb_alu_i),
    .wb_pc_i      (wb_pc_i),
    .wb_funct3_i  (wb_funct3_i),
    .wb_addr_lo_i (wb_addr_lo_i),
    .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i (dmem_rdata_i),
    .AddrD_o      (AddrD_o),
    .DataD_o      (DataD_o),
    .RegWEn_o     (RegWEn_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One-cycle transfer in IDLE; returns just after the accepting edge.
  task automatic send(input logic [1:0] sel, input logic [4:0] rd,
                      input logic [XLEN-1:0] alu, input logic [XLEN-1:0] pc,
                      input logic [2:0] f3, input logic [1:0] lo);
    wb_valid_i   = 1'b1;
    wb_sel_i     = sel;
    wb_rd_i      = rd;
    wb_alu_i     = alu;
    wb_pc_i      = pc;
    wb_funct3_i  = f3;
    wb_addr_lo_i = lo;
    step();
    wb_valid_i   = 1'b0;
  endtask

  // Load: accept, wait gap extra cycles, then a one-cycle response.
  // Returns just after the response (push) edge and checks address/error.
  task automatic do_load(input string tag, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [1:0] lo,
                         input logic [XLEN-1:0] rdata, input int gap,
                         input logic exp_err);
    send(2'b01, rd, '0, '0, f3, lo);
    check({tag, " ready_in_wait"}, 32'(wb_ready_o), 32'd0);
    repeat (gap) step();
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdata;
    step();
    dmem_rvalid_i = 1'b0;
    check({tag, " addr"}, 32'(AddrD_o), 32'(rd));
    check({tag, " err"},  32'(err_o),   32'(exp_err));
    check({tag, " ready_after"}, 32'(wb_ready_o), 32'd1);
  endtask

  // Called just after a push edge: checks the write WB_ADDR_LEAD edges later.
  task automatic check_wb(input string tag, input logic exp_we,
                          input logic [XLEN-1:0] exp_data);
    repeat (3) step();
    check({tag, " we"}, 32'(RegWEn_o), 32'(exp_we));
    if (exp_we) check({tag, " data"}, DataD_o, exp_data);
  endtask

  initial begin
    rst_ni        = 1'b0;
    wb_valid_i    = 1'b0;
    wb_rd_i       = '0;
    wb_sel_i      = '0;
    wb_alu_i      = '0;
    wb_pc_i       = '0;
    wb_funct3_i   = '0;
    wb_addr_lo_i  = '0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = '0;

    // ---- reset state --------------------------------------------------------
    step();
    step();
    check("rst ready", 32'(wb_ready_o), 32'd0);
    check("rst addr",  32'(AddrD_o),    32'd0);
    check("rst data",  DataD_o,         32'd0);
    check("rst we",    32'(RegWEn_o),   32'd0);
    check("rst err",   32'(err_o),      32'd0);
    rst_ni = 1'b1;
    #1;
    check("release ready", 32'(wb_ready_o), 32'd1);

    // ---- ALU write with address lead ----------------------------------------
    send(2'b00, 5'd5, 32'hDEADBEEF, '0, '0, '0);
    check("alu addr", 32'(AddrD_o), 32'd5);
    check("alu we_early", 32'(RegWEn_o), 32'd0);
    step();
    check("alu addr_clear", 32'(AddrD_o), 32'd0);
    step();
    check("alu we_still_low", 32'(RegWEn_o), 32'd0);
    step();
    check("alu we", 32'(RegWEn_o), 32'd1);
    check("alu data", DataD_o, 32'hDEADBEEF);
    step();
    check("alu we_one_cycle", 32'(RegWEn_o), 32'd0);

    // ---- load formatting ----------------------------------------------------
    do_load("lb3", 5'd7, 3'b000, 2'd3, 32'h80FF0000, 1, 1'b0);
    check_wb("lb3", 1'b1, 32'hFFFFFF80);
    do_load("lhu2", 5'd8, 3'b101, 2'd2, 32'h80011234, 0, 1'b0);
    check_wb("lhu2", 1'b1, 32'h00008001);
    do_load("lh2", 5'd8, 3'b001, 2'd2, 32'h80011234, 0, 1'b0);
    check_wb("lh2", 1'b1, 32'hFFFF8001);
    do_load("lbu1", 5'd9, 3'b100, 2'd1, 32'h0000A500, 0, 1'b0);
    check_wb("lbu1", 1'b1, 32'h000000A5);
    do_load("lh0", 5'd9, 3'b001, 2'd0, 32'h12348765, 0, 1'b0);
    check_wb("lh0", 1'b1, 32'hFFFF8765);
    do_load("lw0", 5'd10, 3'b010, 2'd0, 32'hCAFEF00D, 2, 1'b0);
    check_wb("lw0", 1'b1, 32'hCAFEF00D);

    // ---- PC+4 wrap and x0 suppression ---------------------------------------
    send(2'b10, 5'd1, '0, 32'hFFFFFFFC, '0, '0);
    check("jal addr", 32'(AddrD_o), 32'd1);
    check_wb("jal_wrap", 1'b1, 32'h00000000);
    send(2'b10, 5'd2, '0, 32'h00001000, '0, '0);
    check_wb("jal", 1'b1, 32'h00001004);
    send(2'b00, 5'd0, 32'h12345678, '0, '0, '0);
    check_wb("alu_x0", 1'b0, '0);
    send(2'b10, 5'd0, '0, 32'h00000100, '0, '0);
    check_wb("jal_x0", 1'b0, '0);
    do_load("lw_x0", 5'd0, 3'b010, 2'd0, 32'h11111111, 0, 1'b0);
    check_wb("lw_x0", 1'b0, '0);
    send(2'b11, 5'd6, 32'h55555555, '0, '0, '0);
    check_wb("sel11", 1'b0, '0);

    // ---- load errors --------------------------------------------------------
    do_load("lw_mis", 5'd11, 3'b010, 2'd1, 32'h01020304, 0, 1'b1);
    step();
    check("lw_mis err_pulse", 32'(err_o), 32'd0);
    repeat (2) step();
    check("lw_mis we", 32'(RegWEn_o), 32'd0);
    do_load("lh_mis", 5'd12, 3'b001, 2'd3, 32'h01020304, 0, 1'b1);
    check_wb("lh_mis", 1'b0, '0);
    do_load("lhu_mis", 5'd12, 3'b101, 2'd1, 32'h01020304, 0, 1'b1);
    check_wb("lhu_mis", 1'b0, '0);
    do_load("f3_011", 5'd13, 3'b011, 2'd0, 32'h01020304, 0, 1'b1);
    check_wb("f3_011", 1'b0, '0);
    do_load("f3_111", 5'd13, 3'b111, 2'd0, 32'h01020304, 0, 1'b1);
    check_wb("f3_111", 1'b0, '0);

    // ---- stray response in IDLE is ignored ----------------------------------
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hFFFFFFFF;
    step();
    dmem_rvalid_i = 1'b0;
    check("idle_rvalid addr", 32'(AddrD_o), 32'd0);
    check("idle_rvalid err",  32'(err_o),   32'd0);
    check_wb("idle_rvalid", 1'b0, '0);

    // ---- back-to-back ALU writes --------------------------------------------
    for (int i = 1; i <= 4; i++) begin
      wb_valid_i = 1'b1;
      wb_sel_i   = 2'b00;
      wb_rd_i    = 5'(i);
      wb_alu_i   = 32'(i) * 32'h11111111;
      check($sformatf("b2b ready%0d", i), 32'(wb_ready_o), 32'd1);
      step();
      check($sformatf("b2b addr%0d", i), 32'(AddrD_o), 32'(i));
    end
    wb_valid_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("b2b we%0d", i),   32'(RegWEn_o), 32'd1);
      check($sformatf("b2b data%0d", i), DataD_o, 32'(i) * 32'h11111111);
      step();
    end
    check("b2b done", 32'(RegWEn_o), 32'd0);

    // ---- reset mid-load with a queued write ---------------------------------
    send(2'b00, 5'd3, 32'hA5A5A5A5, '0, '0, '0);
    send(2'b01, 5'd14, '0, '0, 3'b010, 2'd0);
    check("rstld ready_wait", 32'(wb_ready_o), 32'd0);
    rst_ni        = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h0BADF00D;
    #1;
    check("rstld ready_in_rst", 32'(wb_ready_o), 32'd0);
    step();
    rst_ni        = 1'b1;
    dmem_rvalid_i = 1'b0;
    #1;
    check("rstld ready_release", 32'(wb_ready_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rstld we%0d", i),   32'(RegWEn_o), 32'd0);
      check($sformatf("rstld addr%0d", i), 32'(AddrD_o),  32'd0);
      step();
    end
    // Block is usable again after the abandoned load.
    send(2'b00, 5'd15, 32'h0000BEEF, '0, '0, '0);
    check_wb("post_rst", 1'b1, 32'h0000BEEF);

`ifdef WB_LOAD_TIMEOUT_EN
    // ---- load timeout -------------------------------------------------------
    send(2'b01, 5'd16, '0, '0, 3'b010, 2'd0);
    for (int i = 1; i <= 15; i++) begin
      step();
      check($sformatf("tmo quiet%0d", i), 32'(err_o), 32'd0);
    end
    step();
    check("tmo err",   32'(err_o),      32'd1);
    check("tmo ready", 32'(wb_ready_o), 32'd1);
    check("tmo addr",  32'(AddrD_o),    32'd0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h76543210;
    step();
    dmem_rvalid_i = 1'b0;
    check("tmo late_err",  32'(err_o),   32'd0);
    check("tmo late_addr", 32'(AddrD_o), 32'd0);
    check_wb("tmo", 1'b0, '0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
